data_mem_ctrl: RTL

Parametrised data-memory access controller between the core's load/store stage and a ready/valid memory bus. It supersedes the single-cycle DPI data memory path with a real handshake and little-endian byte-lane alignment. It adds write strobes, load sign/zero extension from the addressed lane, misalignment detection and tolerance of arbitrary bus latency. One transaction is outstanding at a time.

---
 rtl/data_mem_ctrl_if.sv | 36 +++
 rtl/data_mem_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load/store port bundle: core request/response side plus the ready/valid memory bus.
// The controller uses the slave modport; the environment (core + memory) uses master.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [2:0]            mem_op;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rdata;
  logic                  rsp_err;
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_wr;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_rsp_valid;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  req_valid, req_wr, mem_op, addr, wdata, bus_req_ready, bus_rsp_valid, bus_rdata,
    output req_ready, rsp_valid, rdata, rsp_err, bus_req_valid, bus_wr, bus_addr,
           bus_wstrb, bus_wdata
  );

  modport master (
    output req_valid, req_wr, mem_op, addr, wdata, bus_req_ready, bus_rsp_valid, bus_rdata,
    input  req_ready, rsp_valid, rdata, rsp_err, bus_req_valid, bus_wr, bus_addr,
           bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: one outstanding load/store at a time, little-endian
// lane alignment, write strobes, load sign/zero extension and misalignment errors.
module data_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  data_mem_ctrl_if.slave bus_if
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

  state_t              state_q;
  logic                wr_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [LSB_W-1:0]    lsb_q;
  logic [3:0]          size_q;
  logic                req_illegal;
  logic                req_misaligned;
  logic [STRB_W-1:0]   lane_en;
  logic [DATA_W-1:0]   load_shifted;
  logic [DATA_W-1:0]   load_mask;
  logic                load_sign;
  logic [DATA_W-1:0]   load_ext;

  assign lsb_q  = addr_q[LSB_W-1:0];
  assign size_q = 4'd1 << op_q[1:0];

  always_comb begin
    req_illegal = (bus_if.mem_op == 3'b111) ||
                  ((DATA_W == 32) && ((bus_if.mem_op == 3'b011) || (bus_if.mem_op == 3'b110)));
    case (bus_if.mem_op[1:0])
      2'd1:    req_misaligned = bus_if.addr[0];
      2'd2:    req_misaligned = |bus_if.addr[1:0];
      2'd3:    req_misaligned = |bus_if.addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // A lane is written when it falls inside [lsb, lsb + size).
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    assign lane_en[gi] = (gi >= int'(lsb_q)) && (gi < int'(lsb_q) + int'(size_q));
  end

  // Extension is folded in before capture so RData comes straight from a register.
  always_comb begin
    load_shifted = bus_if.bus_rdata >> {lsb_q, 3'b000};
    case (op_q[1:0])
      2'd0: begin
        load_mask = DATA_W'(8'hFF);
        load_sign = load_shifted[7];
      end
      2'd1: begin
        load_mask = DATA_W'(16'hFFFF);
        load_sign = load_shifted[15];
      end
      2'd2: begin
        load_mask = DATA_W'(32'hFFFF_FFFF);
        load_sign = load_shifted[31];
      end
      default: begin
        load_mask = '1;
        load_sign = load_shifted[DATA_W-1];
      end
    endcase
    load_ext = (load_shifted & load_mask) | ((load_sign && !op_q[2]) ? ~load_mask : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_if.req_valid) begin
            wr_q    <= bus_if.req_wr;
            op_q    <= bus_if.mem_op;
            addr_q  <= bus_if.addr;
            wdata_q <= bus_if.wdata;
            rdata_q <= '0;
            state_q <= (req_illegal || req_misaligned) ? ERR : REQ;
          end
        end
        REQ: begin
          if (bus_if.bus_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (bus_if.bus_rsp_valid) begin
            if (!wr_q) rdata_q <= load_ext;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.req_ready     = (state_q == IDLE);
  assign bus_if.bus_req_valid = (state_q == REQ);
  assign bus_if.bus_wr        = (state_q == REQ) && wr_q;
  assign bus_if.bus_addr      = (state_q == REQ) ? {addr_q[ADDR_W-1:LSB_W], {LSB_W{1'b0}}} : '0;
  assign bus_if.bus_wstrb     = bus_if.bus_wr ? lane_en : '0;
  assign bus_if.bus_wdata     = bus_if.bus_wr ? (wdata_q << {lsb_q, 3'b000}) : '0;
  assign bus_if.rsp_valid     = (state_q == RESP) || (state_q == ERR);
  assign bus_if.rsp_err       = (state_q == ERR);
  assign bus_if.rdata         = (state_q == RESP) ? rdata_q : '0;
endmodule
